// File: rtl/param_bus_datapath.sv
// Single-bus datapath: register file, Y/Z latches, HI/LO and ALU driven by a 3-step sequencer.
// Define DATAPATH_MUL_EN to build the multiplier (ops 6 MUL, 7 MFHI); otherwise those ops flag err.
module param_bus_datapath #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int R0_ZERO  = 0,
  localparam int RA_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [RA_W-1:0]   cmd_ra,
  input  logic [RA_W-1:0]   cmd_rb,
  input  logic [RA_W-1:0]   cmd_rc,
  output logic              done,
  output logic              err,
  input  logic              ext_we,
  input  logic [RA_W-1:0]   ext_waddr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [RA_W-1:0]   dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);
  localparam int SH_W = $clog2(DATA_W);
`ifdef DATAPATH_MUL_EN
  localparam int ZW = 2 * DATA_W;
`else
  // Without the multiplier the Z high half is always zero, so it is not kept.
  localparam int ZW = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

  state_t                         state;
  logic [NUM_REGS-1:0][DATA_W-1:0] rf;
  logic [2:0]                     op;
  logic [RA_W-1:0]                ra, rb, rc;
  logic [DATA_W-1:0]              y, hi, lo, bus;
  logic [ZW-1:0]                  z, alu;
  logic                           unsup, wr_en;

  function automatic logic is_zero_reg(input logic [RA_W-1:0] a);
    return (R0_ZERO != 0) && (a == '0);
  endfunction

  assign cmd_ready = (state == IDLE) && clr;
  assign dbg_rdata = is_zero_reg(dbg_raddr) ? '0 : rf[dbg_raddr];
  assign bus_out   = bus;
  assign hi_out    = hi;
  assign lo_out    = lo;

  always_comb begin
    bus = '0;
    case (state)
      T1:      bus = (op == 3'd7) ? hi : (is_zero_reg(ra) ? '0 : rf[ra]);
      T2:      bus = is_zero_reg(rb) ? '0 : rf[rb];
      T3:      bus = z[DATA_W-1:0];
      default: bus = '0;
    endcase
  end

  // Y holds operand A; the bus carries operand B during T2.
  always_comb begin
    alu = '0;
    case (op)
      3'd0: alu[DATA_W-1:0] = y + bus;
      3'd1: alu[DATA_W-1:0] = y - bus;
      3'd2: alu[DATA_W-1:0] = y & bus;
      3'd3: alu[DATA_W-1:0] = y | bus;
      3'd4: alu[DATA_W-1:0] = y << bus[SH_W-1:0];
      3'd5: alu[DATA_W-1:0] = y >> bus[SH_W-1:0];
`ifdef DATAPATH_MUL_EN
      3'd6: alu = {{DATA_W{1'b0}}, y} * {{DATA_W{1'b0}}, bus};
      3'd7: alu[DATA_W-1:0] = y;
`endif
      default: alu = '0;
    endcase
  end

`ifdef DATAPATH_MUL_EN
  assign unsup = 1'b0;
`else
  assign unsup = (op[2:1] == 2'b11);
`endif
  assign wr_en = !unsup && !is_zero_reg(rc);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      rf    <= '0;
      y     <= '0;
      z     <= '0;
      hi    <= '0;
      lo    <= '0;
      op    <= '0;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // External loads land on the accept edge too, so T1 sees the new value.
          if (ext_we && !is_zero_reg(ext_waddr)) rf[ext_waddr] <= ext_wdata;
          if (cmd_valid) begin
            op    <= cmd_op;
            ra    <= cmd_ra;
            rb    <= cmd_rb;
            rc    <= cmd_rc;
            state <= T1;
          end
        end
        T1: begin
          y     <= bus;
          state <= T2;
        end
        T2: begin
          z     <= alu;
          state <= T3;
        end
        default: begin
          if (wr_en) rf[rc] <= bus;
`ifdef DATAPATH_MUL_EN
          if (op == 3'd6) begin
            hi <= z[ZW-1:DATA_W];
            lo <= z[DATA_W-1:0];
          end
`endif
          done  <= 1'b1;
          err   <= unsup;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
